// File: rtl/booth_radix4_multiplier_if.sv
// Operand/result bundle for booth_radix4_multiplier.
//   in_valid/in_ready  : operand handshake (a, b, is_signed)
//   out_valid/out_ready: result handshake (product)
//   busy               : multiplier is in CALC or DONE
// The master drives operands and consumes the product. The slave is the multiplier.
interface booth_radix4_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, one Booth step per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : booth_radix4_multiplier_if slave modport (operands in, product out)
// Operands are extended to WIDTH+2 bits, so WIDTH/2+1 steps cover the full
// multiplier for both signed and unsigned inputs.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | stepping the Booth recoder, counter counts down to 0
// DONE  | product valid, held until out_ready
module booth_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  booth_radix4_multiplier_if.slave   bus
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 3;
  localparam int RW = AW + EW + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       reg_q, reg_d;
  logic [EW-1:0]       m_q, m_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  product_q, product_d;

  logic [EW-1:0]       a_ext;
  logic [EW-1:0]       b_ext;
  logic signed [AW-1:0] m_aw;
  logic signed [AW-1:0] digit;
  logic signed [AW-1:0] acc_sum;
  logic signed [RW-1:0] stepped;

  assign a_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
  assign b_ext = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

  // One extra bit of headroom so +/-2M never wraps in the accumulator.
  assign m_aw = {m_q[EW-1], m_q};

  always_comb begin
    digit = '0;
    unique case (reg_q[2:0])
      3'b001, 3'b010: digit = m_aw;
      3'b011:         digit = m_aw <<< 1;
      3'b100:         digit = -(m_aw <<< 1);
      3'b101, 3'b110: digit = -m_aw;
      default:        digit = '0;
    endcase
  end

  assign acc_sum = $signed(reg_q[RW-1 -: AW]) + digit;
  assign stepped = $signed({acc_sum, reg_q[EW:0]}) >>> 2;

  always_comb begin
    state_d   = state_q;
    reg_d     = reg_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          m_d     = a_ext;
          reg_d   = {{AW{1'b0}}, b_ext, 1'b0};
          cnt_d   = CW'(N);
          state_d = CALC;
        end
      end
      CALC: begin
        reg_d = stepped;
        cnt_d = cnt_q - CW'(1);
        // Terminal count: this edge performs the last step.
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = stepped[2*WIDTH:1];
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      reg_q     <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      reg_q     <= reg_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.product   = product_q;
endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and 4..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand request.
REQ-005 SHALL have port in_ready  output  1  high only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 SHALL have port out_valid  output  1  product available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts product.
REQ-011 SHALL have port product  output  2*WIDTH  exact product of a and b.
REQ-012 SHALL have port busy  output  1  high in CALC and DONE.

Function
REQ-013 SHALL implement three states: IDLE, CALC, DONE.
REQ-014 SHALL accept operands on a rising edge where the state is IDLE and in_valid=1, then enter CALC.
REQ-015 SHALL latch a, b and is_signed at acceptance; input changes after acceptance SHALL have no effect.
REQ-016 SHALL extend a and b to WIDTH+2 bits at acceptance: sign-extend when is_signed=1, zero-extend when is_signed=0.
REQ-017 SHALL initialise the internal register at acceptance as {accumulator = 0, extended b, appended 0 bit}.
REQ-018 SHALL perform exactly N = WIDTH/2+1 radix-4 Booth steps in CALC, one step per clock.
REQ-019 SHALL take the digit for each step from the low 3 register bits using this mapping: 000 and 111 give 0, 001 and 010 give +M, 011 gives +2M, 100 gives -2M, 101 and 110 give -M, where M is the extended a.
REQ-020 SHALL add the digit to the accumulator at a width that cannot overflow (WIDTH+3 bits minimum), then arithmetic-shift the whole register right by 2.
REQ-021 SHALL keep a step counter that loads N at acceptance and decrements once per CALC edge; the edge on which the counter reaches 0 SHALL move the state to DONE.
REQ-022 SHALL produce the first out_valid=1 cycle immediately after edge E0+N, where E0 is the acceptance edge (for WIDTH=8, after E0+5).
REQ-023 SHALL drive product as the low 2*WIDTH bits of {accumulator, shifted multiplier}, excluding the appended bit; this equals a*b exactly under the selected signedness.
REQ-024 SHALL hold out_valid and product stable in DONE until out_ready=1; an edge with out_ready=1 in DONE SHALL return the state to IDLE.
REQ-025 SHALL keep in_ready=0 in CALC and DONE; in_valid in those states SHALL be ignored and SHALL NOT be queued.
REQ-026 SHALL need one edge of DONE->IDLE before a new acceptance; with in_valid held high, back-to-back throughput is one product per N+2 cycles.
REQ-027 SHALL keep out_valid=0 outside DONE; product SHALL keep its last value outside DONE.
REQ-028 SHALL ignore out_ready outside DONE.

Reset
REQ-029 SHALL, on any edge with rst=1, force the state to IDLE, the counter to 0, the register to 0, out_valid=0, busy=0 and product=0.
REQ-030 SHALL give rst priority over every other event, including acceptance and out_ready in DONE.
REQ-031 SHALL abort a computation in progress when reset arrives in CALC or DONE, with no partial result and no out_valid.
REQ-032 SHALL assert in_ready in the first cycle after rst deasserts.

Verification (WIDTH=8)
REQ-033 SHALL cover: is_signed=1, a=0x80, b=0x80 -> product=0x4000, out_valid first high after E0+5.
REQ-034 SHALL cover: is_signed=0, a=0xFF, b=0xFF -> product=0xFE01; the same operands with is_signed=1 -> product=0x0001.
REQ-035 SHALL cover: is_signed=1, a=0xF9 (-7), b=0x05 -> product=0xFFDD; a=0, b=0xAB -> product=0x0000.
REQ-036 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid and product stable throughout, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-037 SHALL cover: rst pulsed at the third CALC edge -> IDLE, product=0, no out_valid; a new operand pair then completes correctly.
REQ-038 SHALL cover: in_valid toggled with new a and b during CALC -> the result reflects only the first operands; plus a 1000-vector random signed/unsigned sweep against a*b for WIDTH=4, 8 and 16.
